// File: rtl/cnn_loader_pkg.sv
// Shared types and helpers for the CNN tile loader.
package cnn_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_IFM  = 3'd1,
        LD_WGT  = 3'd2,
        LD_BIAS = 3'd3,
        FULL    = 3'd4
    } loader_state_t;

    // Words needed to carry n elements at epw elements per word.
    function automatic int unsigned words_per_window(input int unsigned n, input int unsigned epw);
        return (n + epw - 1) / epw;
    endfunction

endpackage

// File: rtl/window_unpack_reg.sv
// N-element window register, written one input word at a time (LSB slice first).
module window_unpack_reg #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned N          = 9,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 word_idx,
    input  logic [IN_WIDTH-1:0]              word,
    output logic [N-1:0][ELEM_WIDTH-1:0]     window
);

    localparam int unsigned EPW = IN_WIDTH / ELEM_WIDTH;

    // Element e lives in word e/EPW, slice e%EPW; slices past N have no home and drop out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else if (wr_en) begin
            for (int unsigned e = 0; e < N; e++) begin
                if (word_idx == IDX_W'(e / EPW)) begin
                    window[e] <= word[(e % EPW) * ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/cnn_tile_loader.sv
// Unpacks a word stream into an IFM window, a weight window and a bias,
// then hands the tile to the PE array; optionally reuses held weights.
module cnn_tile_loader
    import cnn_loader_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned KERNEL     = 3,
    parameter int unsigned BIAS_WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       reuse_wgt,
    input  logic [IN_WIDTH-1:0]                        in_data,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [KERNEL*KERNEL-1:0][ELEM_WIDTH-1:0]   out_ifm,
    output logic [KERNEL*KERNEL-1:0][ELEM_WIDTH-1:0]   out_wgt,
    output logic [BIAS_WIDTH-1:0]                      out_bias,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy
);

    localparam int unsigned N     = KERNEL * KERNEL;
    localparam int unsigned EPW   = IN_WIDTH / ELEM_WIDTH;
    localparam int unsigned WPW   = words_per_window(N, EPW);
    localparam int unsigned CNT_W = (WPW > 1) ? $clog2(WPW) : 1;

    loader_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   reuse_q, reuse_d;
    logic                   wgt_loaded_q, wgt_loaded_d;
    logic [BIAS_WIDTH-1:0]  bias_d;
    logic                   ifm_we, wgt_we;
    logic                   accept, last_word;

    assign accept    = in_valid && in_ready;
    assign last_word = (cnt_q == CNT_W'(WPW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            reuse_q      <= 1'b0;
            wgt_loaded_q <= 1'b0;
            out_bias     <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reuse_q      <= reuse_d;
            wgt_loaded_q <= wgt_loaded_d;
            out_bias     <= bias_d;
            // Handshake flags are decodes of the next state, so they track state_q exactly.
            in_ready     <= (state_d == LD_IFM) || (state_d == LD_WGT) || (state_d == LD_BIAS);
            out_valid    <= (state_d == FULL);
            busy         <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reuse_d      = reuse_q;
        wgt_loaded_d = wgt_loaded_q;
        bias_d       = out_bias;
        ifm_we       = 1'b0;
        wgt_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_IFM;
                    cnt_d   = '0;
                    reuse_d = reuse_wgt && wgt_loaded_q;
                end
            end
            LD_IFM: begin
                if (accept) begin
                    ifm_we = 1'b1;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = reuse_q ? FULL : LD_WGT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LD_WGT: begin
                if (accept) begin
                    wgt_we = 1'b1;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = LD_BIAS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LD_BIAS: begin
                if (accept) begin
                    bias_d       = in_data[BIAS_WIDTH-1:0];
                    wgt_loaded_d = 1'b1;
                    state_d      = FULL;
                end
            end
            FULL: begin
                // A start alongside the hand-off chains straight into the next tile.
                if (out_valid && out_ready) begin
                    if (start) begin
                        state_d = LD_IFM;
                        cnt_d   = '0;
                        reuse_d = reuse_wgt && wgt_loaded_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    window_unpack_reg #(
        .IN_WIDTH   (IN_WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH),
        .N          (N),
        .IDX_W      (CNT_W)
    ) u_ifm (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (ifm_we),
        .word_idx (cnt_q),
        .word     (in_data),
        .window   (out_ifm)
    );

    window_unpack_reg #(
        .IN_WIDTH   (IN_WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH),
        .N          (N),
        .IDX_W      (CNT_W)
    ) u_wgt (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wgt_we),
        .word_idx (cnt_q),
        .word     (in_data),
        .window   (out_wgt)
    );

endmodule

// File: tb/tb_cnn_tile_loader.sv
// Randomized self-checking bench for cnn_tile_loader against a tile-level model.
module tb_cnn_tile_loader;

    localparam int IW = 32, EW = 8, KN = 3, BW = 8;
    localparam int N = KN * KN, EPW = IW / EW, WPW = (N + EPW - 1) / EPW;
    localparam int EW5 = 16, N5 = 25, EPW5 = IW / EW5, WPW5 = (N5 + EPW5 - 1) / EPW5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   start = 1'b0, reuse_wgt = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [IW-1:0]          in_data = '0;
    logic                   in_ready, out_valid, busy;
    logic [N-1:0][EW-1:0]   out_ifm, out_wgt;
    logic [BW-1:0]          out_bias;

    logic                   start5 = 1'b0, in_valid5 = 1'b0, out_ready5 = 1'b0;
    logic [IW-1:0]          in_data5 = '0;
    logic                   in_ready5, out_valid5, busy5;
    logic [N5-1:0][EW5-1:0] out_ifm5, out_wgt5;
    logic [BW-1:0]          out_bias5;

    cnn_tile_loader #(.IN_WIDTH(IW), .ELEM_WIDTH(EW), .KERNEL(KN), .BIAS_WIDTH(BW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reuse_wgt(reuse_wgt),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_ifm(out_ifm), .out_wgt(out_wgt), .out_bias(out_bias),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    cnn_tile_loader #(.IN_WIDTH(IW), .ELEM_WIDTH(EW5), .KERNEL(5), .BIAS_WIDTH(BW)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .reuse_wgt(1'b0),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_ifm(out_ifm5), .out_wgt(out_wgt5), .out_bias(out_bias5),
        .out_valid(out_valid5), .out_ready(out_ready5), .busy(busy5)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] m_ifm [N];
    logic [EW-1:0] m_wgt [N];
    logic [BW-1:0] m_bias;
    bit            m_wgt_loaded;
    logic [IW-1:0] words [$];

    logic [EW-1:0] d_ifm [N] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hF9};
    logic [EW-1:0] d_wgt [N] = '{8'h03, 8'hFD, 8'hFE, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h0A};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < N; e++) begin
            m_ifm[e] = '0;
            m_wgt[e] = '0;
        end
        m_bias       = '0;
        m_wgt_loaded = 1'b0;
    endtask

    task automatic check_tile();
        for (int e = 0; e < N; e++) begin
            check($sformatf("ifm[%0d]", e), 64'(out_ifm[e]), 64'(m_ifm[e]));
            check($sformatf("wgt[%0d]", e), 64'(out_wgt[e]), 64'(m_wgt[e]));
        end
        check("bias", 64'(out_bias), 64'(m_bias));
    endtask

    task automatic check_directed();
        for (int e = 0; e < N; e++) begin
            check($sformatf("dir_ifm[%0d]", e), 64'(out_ifm[e]), 64'(d_ifm[e]));
            check($sformatf("dir_wgt[%0d]", e), 64'(out_wgt[e]), 64'(d_wgt[e]));
        end
        check("dir_bias", 64'(out_bias), 64'd127);
    endtask

    task automatic set_fixed_words();
        words = '{32'h04030201, 32'h08070605, 32'h000000F9, 32'hFFFEFD03,
                  32'h07060504, 32'h0000000A, 32'h0000007F};
    endtask

    // Streams words[0..stop_at-1] with optional random gaps and stray start pulses.
    task automatic stream(input int stop_at, input bit gaps);
        int idx = 0;
        int guard = 0;
        while (idx < stop_at && guard < 1000) begin
            check("in_ready_load", 64'(in_ready), 64'd1);
            check("out_valid_load", 64'(out_valid), 64'd0);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? words[idx] : $urandom;
            start    = ($urandom_range(0, 3) == 0);
            if (in_valid) idx++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (guard >= 1000) check("stream_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue_start(input bit reuse);
        @(negedge clk);
        start     = 1'b1;
        reuse_wgt = reuse;
        @(negedge clk);
        start     = 1'b0;
        reuse_wgt = 1'($urandom);
    endtask

    // One full tile; when chained the start rides on the hand-off of the previous tile.
    task automatic load_tile(input bit reuse, input bit gaps, input bit fixed, input bit chained);
        bit eff;
        int nw;
        eff = reuse && m_wgt_loaded;
        nw  = eff ? WPW : 2 * WPW + 1;
        if (!fixed) begin
            words.delete();
            repeat (nw) words.push_back($urandom);
        end
        if (chained) begin
            out_ready = 1'b1;
            start     = 1'b1;
            reuse_wgt = reuse;
            @(negedge clk);
            out_ready = 1'b0;
            start     = 1'b0;
            check("b2b_out_valid", 64'(out_valid), 64'd0);
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            check("b2b_busy", 64'(busy), 64'd1);
        end else begin
            issue_start(reuse);
        end
        stream(nw, gaps);
        for (int e = 0; e < N; e++) begin
            m_ifm[e] = EW'(words[e / EPW] >> ((e % EPW) * EW));
            if (!eff) m_wgt[e] = EW'(words[WPW + e / EPW] >> ((e % EPW) * EW));
        end
        if (!eff) begin
            m_bias       = BW'(words[2 * WPW]);
            m_wgt_loaded = 1'b1;
        end
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        check_tile();
    endtask

    task automatic hold_full(input int cycles);
        repeat (cycles) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check_tile();
        end
        start = 1'b0;
    endtask

    task automatic release_tile();
        out_ready = 1'b1;
        start     = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_busy", 64'(busy), 64'd0);
        check("rel_in_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check_tile();
    endtask

    initial begin
        bit chained;
        bit next_chained;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Directed tile; reuse requested before any weights exist, so a full load is expected.
        set_fixed_words();
        load_tile(1'b1, 1'b0, 1'b1, 1'b0);
        check_directed();
        release_tile();

        // Weight reuse: only IFM words, weights and bias retained.
        load_tile(1'b1, 1'b0, 1'b0, 1'b0);
        release_tile();

        // Backpressure on both sides with the directed data.
        set_fixed_words();
        load_tile(1'b0, 1'b1, 1'b1, 1'b0);
        hold_full(5);
        check_directed();
        release_tile();

        // Randomized tiles, some chained back-to-back.
        chained = 1'b0;
        for (int i = 0; i < 10; i++) begin
            load_tile(1'($urandom), 1'($urandom), 1'b0, chained);
            hold_full(int'($urandom_range(0, 2)));
            next_chained = (i < 9) && 1'($urandom);
            if (!next_chained) release_tile();
            chained = next_chained;
        end

        // Reset mid-load aborts the tile and forgets the weights.
        words.delete();
        repeat (2 * WPW + 1) words.push_back($urandom);
        issue_start(1'b0);
        stream(4, 1'b0);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        load_tile(1'b1, 1'b0, 1'b0, 1'b0);
        release_tile();

        // KERNEL=5, 16-bit elements: 13 words per window, 27 words per tile.
        begin
            logic [IW-1:0] w5 [$];
            repeat (2 * WPW5 + 1) w5.push_back($urandom | 32'h0001_0000);
            @(negedge clk);
            start5 = 1'b1;
            @(negedge clk);
            start5 = 1'b0;
            for (int i = 0; i < 2 * WPW5 + 1; i++) begin
                if (i == 0 || i == 2 * WPW5) begin
                    check("v5_in_ready", 64'(in_ready5), 64'd1);
                    check("v5_out_valid_early", 64'(out_valid5), 64'd0);
                end
                in_valid5 = 1'b1;
                in_data5  = w5[i];
                @(negedge clk);
            end
            in_valid5 = 1'b0;
            check("v5_out_valid", 64'(out_valid5), 64'd1);
            check("v5_in_ready_full", 64'(in_ready5), 64'd0);
            for (int e = 0; e < N5; e++) begin
                check($sformatf("v5_ifm[%0d]", e), 64'(out_ifm5[e]),
                      64'(EW5'(w5[e / EPW5] >> ((e % EPW5) * EW5))));
                check($sformatf("v5_wgt[%0d]", e), 64'(out_wgt5[e]),
                      64'(EW5'(w5[WPW5 + e / EPW5] >> ((e % EPW5) * EW5))));
            end
            check("v5_bias", 64'(out_bias5), 64'(BW'(w5[2 * WPW5])));
            out_ready5 = 1'b1;
            @(negedge clk);
            out_ready5 = 1'b0;
            check("v5_release", 64'(out_valid5), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
